lowpass_decimator: RTL and testbench

Per-channel integer decimator placed directly after the low-pass FIR in the receive chain. It takes the FIR's 24-bit filtered samples, tagged with a 3-bit channel index, over AXI-Stream. For each of the 8 channels independently it forwards one sample in every DECIM and discards the rest. Kept samples pass through a 2-entry output FIFO to the downstream beamforming/correlation stage.

---
 rtl/lowpass_decimator_if.sv | 24 ++
 rtl/lowpass_decimator.sv | 103 ++++++++++
 tb/tb_lowpass_decimator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lowpass_decimator_if.sv
// rtl/lowpass_decimator_if.sv - sample stream with channel tag, master/slave views
interface lowpass_decimator_if #(
  parameter int DATA_W = 24,
  parameter int CH_W   = 3
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic [CH_W-1:0]   tuser;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/lowpass_decimator.sv
// rtl/lowpass_decimator.sv - per-channel keep-one-in-DECIM decimator with 2-entry output FIFO
module lowpass_decimator #(
  parameter int DECIM  = 16,
  parameter int DATA_W = 24,
  parameter int CH_W   = 3
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_arst,
  input  logic                phase_clr,
  lowpass_decimator_if.slave  s_axis,
  lowpass_decimator_if.master m_axis
);

  localparam int NCH   = 1 << CH_W;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ENT_W = CH_W + DATA_W;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0]  phase_q [NCH];
  logic [PH_W-1:0]  phase_d [NCH];
  logic [ENT_W-1:0] mem_q [2];
  logic [ENT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [ENT_W-1:0] out_q, out_d;

  logic             accept;
  logic             keep;
  logic             rd;
  logic [PH_W-1:0]  cur_phase;

  // Ready and valid come only from the registered fill level.
  assign s_axis.tready = (count_q != 2'd2);
  assign m_axis.tvalid = (count_q != 2'd0);
  assign {m_axis.tuser, m_axis.tdata} = out_q;

  // Phase bookkeeping, FIFO write/read and head selection.
  always_comb begin
    phase_d   = phase_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_d     = out_q;
    cur_phase = phase_q[s_axis.tuser];
    accept    = s_axis.tvalid && (count_q != 2'd2);
    keep      = accept && (cur_phase == '0);
    rd        = (count_q != 2'd0) && m_axis.tready;

    if (accept) begin
      phase_d[s_axis.tuser] = (cur_phase == PH_LAST) ? '0 : cur_phase + PH_W'(1);
    end
    // Clear wins over the advance; the keep decision above already used the old phase.
    if (phase_clr) begin
      for (int i = 0; i < NCH; i++) begin
        phase_d[i] = '0;
      end
    end

    if (keep) begin
      mem_d[wr_ptr_q] = {s_axis.tuser, s_axis.tdata};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (rd) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({keep, rd})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Output register tracks the head; when empty it keeps the last value shown.
    if (count_d != 2'd0) begin
      out_d = mem_d[rd_ptr_d];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge s_axis_aclk or posedge s_axis_arst) begin
    if (s_axis_arst) begin
      for (int i = 0; i < NCH; i++) begin
        phase_q[i] <= '0;
      end
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      out_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_lowpass_decimator.sv
// tb/tb_lowpass_decimator.sv - directed vector bench for lowpass_decimator
module tb_lowpass_decimator;

  logic clk;
  logic rst;
  logic clr4;
  logic clr1;
  int   total;
  int   bad;

  lowpass_decimator_if #(.DATA_W(24), .CH_W(3)) s4 ();
  lowpass_decimator_if #(.DATA_W(24), .CH_W(3)) m4 ();
  lowpass_decimator_if #(.DATA_W(24), .CH_W(3)) s1 ();
  lowpass_decimator_if #(.DATA_W(24), .CH_W(3)) m1 ();

  lowpass_decimator #(.DECIM(4), .DATA_W(24), .CH_W(3)) u_dec4 (
    .s_axis_aclk (clk),
    .s_axis_arst (rst),
    .phase_clr   (clr4),
    .s_axis      (s4),
    .m_axis      (m4)
  );

  lowpass_decimator #(.DECIM(1), .DATA_W(24), .CH_W(3)) u_dec1 (
    .s_axis_aclk (clk),
    .s_axis_arst (rst),
    .phase_clr   (clr1),
    .s_axis      (s1),
    .m_axis      (m1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  user;
    logic [23:0] data;
    logic        clr;
    logic        keep;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic vld, logic [2:0] user, logic [23:0] data, logic clr, logic keep);
    vec_t v;
    v.vld  = vld;
    v.user = user;
    v.data = data;
    v.clr  = clr;
    v.keep = keep;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(logic vld, logic [2:0] user, logic [23:0] data);
    s4.tvalid = vld;
    s4.tuser  = user;
    s4.tdata  = data;
  endtask

  task automatic drive1(logic vld, logic [2:0] user, logic [23:0] data);
    s1.tvalid = vld;
    s1.tuser  = user;
    s1.tdata  = data;
  endtask

  task automatic chk1(string tag, logic vld, logic [2:0] user, logic [23:0] data, logic rdy);
    chk({tag, "_tvalid"}, 32'(m1.tvalid), 32'(vld));
    chk({tag, "_tdata"},  32'(m1.tdata),  32'(data));
    chk({tag, "_tuser"},  32'(m1.tuser),  32'(user));
    chk({tag, "_tready"}, 32'(s1.tready), 32'(rdy));
  endtask

  task automatic chk4(string tag, logic vld, logic [2:0] user, logic [23:0] data, logic rdy);
    chk({tag, "_tvalid"}, 32'(m4.tvalid), 32'(vld));
    chk({tag, "_tdata"},  32'(m4.tdata),  32'(data));
    chk({tag, "_tuser"},  32'(m4.tuser),  32'(user));
    chk({tag, "_tready"}, 32'(s4.tready), 32'(rdy));
  endtask

  initial begin
    logic [23:0] last_d;
    logic [2:0]  last_u;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clr4  = 1'b0;
    clr1  = 1'b0;
    drive4(1'b0, 3'd0, 24'd0);
    drive1(1'b0, 3'd0, 24'd0);
    m4.tready = 1'b1;
    m1.tready = 1'b0;

    // DECIM=4, channel 0 only, data 0..11: keep 0, 4, 8
    for (int k = 0; k < 12; k++) add(1'b1, 3'd0, 24'(k), 1'b0, (k % 4) == 0);
    // DECIM=4, channels 0/1 interleaved, data 10*ch+k
    for (int k = 0; k < 8; k++) begin
      add(1'b1, 3'd0, 24'(k),      1'b0, (k % 4) == 0);
      add(1'b1, 3'd1, 24'(10 + k), 1'b0, (k % 4) == 0);
    end
    // channel 2, two beats, clear pulse, four more beats: keep 100 and 102
    add(1'b1, 3'd2, 24'd100, 1'b0, 1'b1);
    add(1'b1, 3'd2, 24'd101, 1'b0, 1'b0);
    add(1'b0, 3'd2, 24'd0,   1'b1, 1'b0);
    add(1'b1, 3'd2, 24'd102, 1'b0, 1'b1);
    add(1'b1, 3'd2, 24'd103, 1'b0, 1'b0);
    add(1'b1, 3'd2, 24'd104, 1'b0, 1'b0);
    add(1'b1, 3'd2, 24'd105, 1'b0, 1'b0);
    // clear coinciding with a beat at phase 1: beat dropped, next beat kept
    add(1'b1, 3'd2, 24'd106, 1'b0, 1'b1);
    add(1'b1, 3'd2, 24'd107, 1'b1, 1'b0);
    add(1'b1, 3'd2, 24'd108, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk4("reset4", 1'b0, 3'd0, 24'd0, 1'b1);
    chk1("reset1", 1'b0, 3'd0, 24'd0, 1'b1);

    last_d = 24'd0;
    last_u = 3'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive4(tbl[i].vld, tbl[i].user, tbl[i].data);
      clr4 = tbl[i].clr;
      step();
      if (tbl[i].keep) begin
        last_d = tbl[i].data;
        last_u = tbl[i].user;
      end
      chk4($sformatf("vec%0d", i), tbl[i].keep, last_u, last_d, 1'b1);
    end
    drive4(1'b0, 3'd0, 24'd0);
    clr4 = 1'b0;

    // DECIM=1 fill to full with downstream stalled, then drain with a held beat
    m1.tready = 1'b0;
    drive1(1'b1, 3'd3, 24'd5);
    step();
    chk1("full_a", 1'b1, 3'd3, 24'd5, 1'b1);
    drive1(1'b1, 3'd4, 24'd6);
    step();
    chk1("full_b", 1'b1, 3'd3, 24'd5, 1'b0);
    drive1(1'b1, 3'd5, 24'd7);
    step();
    chk1("full_hold", 1'b1, 3'd3, 24'd5, 1'b0);
    m1.tready = 1'b1;
    step();
    chk1("drain_a", 1'b1, 3'd4, 24'd6, 1'b1);
    step();
    chk1("drain_b", 1'b1, 3'd5, 24'd7, 1'b1);
    drive1(1'b0, 3'd0, 24'd0);
    step();
    chk1("drain_empty", 1'b0, 3'd5, 24'd7, 1'b1);

    // DECIM=1 count held at 1 by simultaneous read and write
    m1.tready = 1'b0;
    drive1(1'b1, 3'd0, 24'd1);
    step();
    chk1("rw_1", 1'b1, 3'd0, 24'd1, 1'b1);
    m1.tready = 1'b1;
    drive1(1'b1, 3'd0, 24'd2);
    step();
    chk1("rw_2", 1'b1, 3'd0, 24'd2, 1'b1);
    drive1(1'b1, 3'd0, 24'd3);
    step();
    chk1("rw_3", 1'b1, 3'd0, 24'd3, 1'b1);
    drive1(1'b0, 3'd0, 24'd0);
    step();
    chk1("rw_empty", 1'b0, 3'd0, 24'd3, 1'b1);

    // DECIM=4 reset while full with channel 0 phase nonzero
    m4.tready = 1'b0;
    drive4(1'b1, 3'd0, 24'd50);
    step();
    chk4("pre_a", 1'b1, 3'd0, 24'd50, 1'b1);
    for (int k = 51; k <= 53; k++) begin
      drive4(1'b1, 3'd0, 24'(k));
      step();
    end
    chk4("pre_b", 1'b1, 3'd0, 24'd50, 1'b1);
    drive4(1'b1, 3'd0, 24'd54);
    step();
    chk4("pre_full", 1'b1, 3'd0, 24'd50, 1'b0);
    drive4(1'b0, 3'd0, 24'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_tvalid", 32'(m4.tvalid), 32'd0);
    chk("async_tdata",  32'(m4.tdata),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    m4.tready = 1'b1;
    drive4(1'b1, 3'd0, 24'd7);
    step();
    chk4("post_rst", 1'b1, 3'd0, 24'd7, 1'b1);
    drive4(1'b0, 3'd0, 24'd0);
    step();
    chk4("post_rst_empty", 1'b0, 3'd0, 24'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
